// File: rtl/axi_hdr_pkg.sv
// axi_hdr_pkg: FSM state encoding and keep-mask legality check shared by the header arbiter
package axi_hdr_pkg;
  typedef enum logic [1:0] {IDLE, OFFER, WAIT_EOP} state_t;
  function automatic logic keep_is_legal(input logic [63:0] keep);
    return ((keep + 64'd1) & keep) == 64'd0;
  endfunction
endpackage

// File: rtl/axi_stream_header_arbiter_if.sv
// axi_stream_header_arbiter_if: requester side (src_*), insert-header channel (*_insert), output-stream tap (*_out) and status (grant_id, busy, err_*)
interface axi_stream_header_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_WD = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
);
  logic [NUM_SRC-1:0] src_valid;
  logic [NUM_SRC*DATA_WD-1:0] src_header;
  logic [NUM_SRC*DATA_BYTE_WD-1:0] src_keep;
  logic [NUM_SRC-1:0] src_ready;
  logic valid_insert;
  logic [DATA_WD-1:0] header_insert;
  logic [DATA_BYTE_WD-1:0] keep_insert;
  logic ready_insert;
  logic valid_out;
  logic ready_out;
  logic last_out;
  logic [$clog2(NUM_SRC)-1:0] grant_id;
  logic busy;
  logic err_keep;
  logic err_timeout;
  modport slave (
    input src_valid, src_header, src_keep, ready_insert, valid_out, ready_out, last_out,
    output src_ready, valid_insert, header_insert, keep_insert, grant_id, busy, err_keep, err_timeout
  );
  modport master (
    output src_valid, src_header, src_keep, ready_insert, valid_out, ready_out, last_out,
    input src_ready, valid_insert, header_insert, keep_insert, grant_id, busy, err_keep, err_timeout
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first req at or after ptr (wrapping); gnt one-hot, index its position
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] index
);
  logic [IW-1:0] w_j;
  always_comb begin
    gnt = '0;
    index = '0;
    w_j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(ptr) + k) % N);
      if (req[w_j]) begin
        gnt = N'(1) << w_j;
        index = w_j;
      end
    end
  end
endmodule

// File: rtl/axi_stream_header_arbiter.sv
// axi_stream_header_arbiter: round-robin header grant to the insert block, locked until output EOP, with keep check and watchdog (ports: clk, rst, bus = requesters/insert channel/output tap/status)
module axi_stream_header_arbiter
  import axi_hdr_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_WD = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int TIMEOUT = 1024
) (
  input logic clk,
  input logic rst,
  axi_stream_header_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_gid, w_idx;
  logic [NUM_SRC-1:0] w_gnt;
  logic [DATA_WD-1:0] r_hdr, w_hdr;
  logic [DATA_BYTE_WD-1:0] r_keep, w_keep;
  logic [CW-1:0] r_cnt;
  logic r_err_keep, r_err_to, w_hs, w_legal, w_eop, w_to;
  rr_arbiter #(.N(NUM_SRC)) u_rr (.req(bus.src_valid), .ptr(r_ptr), .gnt(w_gnt), .index(w_idx));
  assign w_hs = r_state == IDLE && |bus.src_valid;
  assign w_hdr = bus.src_header[w_idx * DATA_WD +: DATA_WD];
  assign w_keep = bus.src_keep[w_idx * DATA_BYTE_WD +: DATA_BYTE_WD];
  assign w_legal = keep_is_legal(64'(w_keep));
  assign w_eop = bus.valid_out & bus.ready_out & bus.last_out;
  assign w_to = TIMEOUT > 0 && r_cnt == LIM;
  assign bus.src_ready = rst || r_state != IDLE ? '0 : w_gnt;
  assign bus.valid_insert = r_state == OFFER;
  assign bus.busy = r_state != IDLE;
  assign bus.header_insert = r_hdr;
  assign bus.keep_insert = r_keep;
  assign bus.grant_id = r_gid;
  assign bus.err_keep = r_err_keep;
  assign bus.err_timeout = r_err_to;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_hs && w_legal ? OFFER : IDLE;
    else if (r_state == OFFER) w_next = bus.ready_insert ? WAIT_EOP : OFFER;
    else w_next = w_eop || w_to ? IDLE : WAIT_EOP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_gid <= '0;
      r_hdr <= '0;
      r_keep <= '0;
      r_cnt <= '0;
      r_err_keep <= 1'b0;
      r_err_to <= 1'b0;
    end else begin
      r_cnt <= r_state == WAIT_EOP ? r_cnt + CW'(1) : '0;
      r_err_keep <= w_hs && !w_legal;
      r_err_to <= r_state == WAIT_EOP && w_to && !w_eop;
      if (w_hs) begin
        r_ptr <= w_idx == IW'(NUM_SRC - 1) ? '0 : w_idx + IW'(1);
        r_gid <= w_idx;
        if (w_legal) begin
          r_hdr <= w_hdr;
          r_keep <= w_keep;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// tb_axi_stream_header_arbiter: directed and randomized packets checked against a transaction-level round-robin model
module tb_axi_stream_header_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  int rr = 0;
  axi_stream_header_arbiter_if #(.NUM_SRC(4), .DATA_WD(32)) bus ();
  axi_stream_header_arbiter #(.NUM_SRC(4), .DATA_WD(32), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction
  function automatic bit legal(input logic [3:0] k);
    return k inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in;
    bus.src_valid = '0;
    bus.src_header = '0;
    bus.src_keep = '0;
    bus.ready_insert = 1'b0;
    bus.valid_out = 1'b0;
    bus.ready_out = 1'b0;
    bus.last_out = 1'b0;
  endtask
  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if ({bus.valid_insert, bus.header_insert, bus.keep_insert, bus.grant_id, bus.busy, bus.err_keep, bus.err_timeout} !== 42'd0) begin
      n_bad++;
      $display("FAIL %s got vi=%b hdr=%h keep=%b gid=%0d busy=%b ek=%b et=%b exp all zero", tag, bus.valid_insert,
               bus.header_insert, bus.keep_insert, bus.grant_id, bus.busy, bus.err_keep, bus.err_timeout);
    end
  endtask
  // one header request from mask v; eop_dly = idle WAIT_EOP cycles before eop, 16 = never (watchdog)
  task automatic do_packet(input logic [3:0] v, input logic [127:0] h, input logic [15:0] k, input int ins_dly,
                           input int eop_dly, input bit noise);
    int w;
    logic [31:0] eh;
    logic [3:0] ek;
    bus.src_valid = v;
    bus.src_header = h;
    bus.src_keep = k;
    #1;
    w = pick(v, rr);
    eh = h[w*32 +: 32];
    ek = k[w*4 +: 4];
    rr = (w + 1) % 4;
    n_vec++;
    if (bus.src_ready !== 4'(1 << w)) begin
      n_bad++;
      $display("FAIL src_ready got %b exp %b", bus.src_ready, 4'(1 << w));
    end
    tick;
    if (!legal(ek)) begin
      n_vec++;
      if ({bus.err_keep, bus.valid_insert, bus.busy, bus.grant_id} !== {3'b100, 2'(w)}) begin
        n_bad++;
        $display("FAIL keep_reject got ek=%b vi=%b busy=%b gid=%0d exp ek=1 vi=0 busy=0 gid=%0d", bus.err_keep,
                 bus.valid_insert, bus.busy, bus.grant_id, w);
      end
      return;
    end
    n_vec++;
    if ({bus.valid_insert, bus.busy, bus.err_keep, bus.grant_id, bus.header_insert, bus.keep_insert, bus.src_ready} !==
        {3'b110, 2'(w), eh, ek, 4'h0}) begin
      n_bad++;
      $display("FAIL offer got vi=%b busy=%b ek=%b gid=%0d hdr=%h keep=%b rdy=%b exp vi=1 busy=1 ek=0 gid=%0d hdr=%h keep=%b rdy=0000",
               bus.valid_insert, bus.busy, bus.err_keep, bus.grant_id, bus.header_insert, bus.keep_insert,
               bus.src_ready, w, eh, ek);
    end
    for (int i = 0; i < ins_dly; i++) begin
      if (noise) {bus.valid_out, bus.ready_out, bus.last_out} = 3'($urandom);
      tick;
      n_vec++;
      if ({bus.valid_insert, bus.header_insert, bus.keep_insert, bus.src_ready} !== {1'b1, eh, ek, 4'h0}) begin
        n_bad++;
        $display("FAIL offer_hold got vi=%b hdr=%h keep=%b rdy=%b exp vi=1 hdr=%h keep=%b rdy=0000", bus.valid_insert,
                 bus.header_insert, bus.keep_insert, bus.src_ready, eh, ek);
      end
    end
    bus.ready_insert = 1'b1;
    if (noise) {bus.valid_out, bus.ready_out, bus.last_out} = 3'b111;
    tick;
    bus.ready_insert = 1'b0;
    {bus.valid_out, bus.ready_out, bus.last_out} = 3'b000;
    for (int i = 1; i <= eop_dly && i <= 16; i++) begin
      n_vec++;
      if ({bus.valid_insert, bus.busy, bus.err_timeout, bus.src_ready} !== {3'b010, 4'h0}) begin
        n_bad++;
        $display("FAIL wait_eop cyc %0d got vi=%b busy=%b et=%b rdy=%b exp vi=0 busy=1 et=0 rdy=0000", i,
                 bus.valid_insert, bus.busy, bus.err_timeout, bus.src_ready);
      end
      tick;
    end
    if (eop_dly < 16) begin
      {bus.valid_out, bus.ready_out, bus.last_out} = 3'b111;
      tick;
      {bus.valid_out, bus.ready_out, bus.last_out} = 3'b000;
      n_vec++;
      if ({bus.busy, bus.err_timeout, bus.valid_insert} !== 3'b000) begin
        n_bad++;
        $display("FAIL eop_release got busy=%b et=%b vi=%b exp 0 0 0", bus.busy, bus.err_timeout, bus.valid_insert);
      end
    end else begin
      n_vec++;
      if ({bus.busy, bus.err_timeout, bus.valid_insert} !== 3'b010) begin
        n_bad++;
        $display("FAIL timeout got busy=%b et=%b vi=%b exp busy=0 et=1 vi=0", bus.busy, bus.err_timeout,
                 bus.valid_insert);
      end
    end
  endtask
  task automatic test_reset;
    clear_in();
    bus.src_valid = 4'hF;
    rst = 1'b1;
    tick;
    tick;
    n_vec++;
    if (bus.src_ready !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_src_ready got %b exp 0000", bus.src_ready);
    end
    bus.src_valid = '0;
    rst = 1'b0;
    rr = 0;
    check_reset_outputs("reset_outputs");
  endtask
  task automatic test_single;
    do_packet(4'b0100, {32'h0, 32'hAABBCCDD, 64'h0}, {4'h0, 4'b0011, 8'h0}, 0, 2, 1'b0);
    bus.src_valid = '0;
    tick;
  endtask
  task automatic test_round_robin;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    rr = 0;
    for (int p = 0; p < 8; p++) begin
      do_packet(4'hF, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, $urandom_range(0, 2), $urandom_range(0, 5), 1'b0);
      n_vec++;
      if (bus.grant_id !== 2'(p % 4)) begin
        n_bad++;
        $display("FAIL rr_order pkt %0d got %0d exp %0d", p, bus.grant_id, p % 4);
      end
    end
    bus.src_valid = '0;
    tick;
  endtask
  task automatic test_illegal_keep;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    rr = 0;
    do_packet(4'b0010, {$urandom, $urandom, $urandom, $urandom}, 16'h0050, 0, 0, 1'b0);
    bus.src_valid = '0;
    tick;
    n_vec++;
    if ({bus.err_keep, bus.valid_insert, bus.busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL keep_pulse_end got ek=%b vi=%b busy=%b exp 0 0 0", bus.err_keep, bus.valid_insert, bus.busy);
    end
    do_packet(4'hF, {$urandom, $urandom, $urandom, $urandom}, 16'h137F, 1, 3, 1'b0);
    bus.src_valid = '0;
    tick;
  endtask
  task automatic test_timeout;
    do_packet(4'b0001, {$urandom, $urandom, $urandom, $urandom}, 16'h0007, 1, 16, 1'b0);
    bus.src_valid = '0;
    tick;
    n_vec++;
    if ({bus.err_timeout, bus.busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL timeout_pulse_end got et=%b busy=%b exp 0 0", bus.err_timeout, bus.busy);
    end
  endtask
  task automatic test_eop_on_timeout;
    do_packet(4'b1000, {$urandom, $urandom, $urandom, $urandom}, 16'hF000, 0, 15, 1'b0);
    bus.src_valid = '0;
    tick;
    n_vec++;
    if (bus.err_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL eop_wins got et=%b exp 0", bus.err_timeout);
    end
  endtask
  task automatic test_random;
    logic [3:0] lk [5] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
    logic [15:0] k;
    for (int p = 0; p < 30; p++) begin
      for (int s = 0; s < 4; s++)
        k[s*4 +: 4] = $urandom_range(0, 4) == 0 ? 4'($urandom) : lk[$urandom_range(0, 4)];
      do_packet(4'($urandom_range(1, 15)), {$urandom, $urandom, $urandom, $urandom}, k, $urandom_range(0, 3),
                $urandom_range(0, 16), 1'b1);
    end
    bus.src_valid = '0;
    tick;
  endtask
  task automatic test_reset_mid_packet;
    bus.src_valid = 4'b0100;
    bus.src_keep = 16'hFFFF;
    tick;
    bus.src_valid = '0;
    bus.ready_insert = 1'b1;
    tick;
    bus.ready_insert = 1'b0;
    tick;
    n_vec++;
    if ({bus.busy, bus.valid_insert} !== 2'b10) begin
      n_bad++;
      $display("FAIL mid_pre_reset got busy=%b vi=%b exp busy=1 vi=0", bus.busy, bus.valid_insert);
    end
    rst = 1'b1;
    bus.src_valid = 4'hF;
    tick;
    n_vec++;
    if (bus.src_ready !== 4'h0) begin
      n_bad++;
      $display("FAIL mid_rst_ready got %b exp 0000", bus.src_ready);
    end
    check_reset_outputs("mid_rst_outputs");
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.src_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL first_grant_after_rst got %b exp 0001", bus.src_ready);
    end
    bus.src_valid = '0;
    tick;
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_illegal_keep();
    test_timeout();
    test_eop_on_timeout();
    test_random();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
